// File: rtl/pipe_pkg.sv
// Shared pipeline control types: FSM states, scoreboard entries and forwarding selects.
package pipe_pkg;

  localparam int unsigned RD_W     = 5;
  localparam logic [6:0]  OPC_LOAD = 7'b0000011;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    WAIT   = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic            valid;
    logic [RD_W-1:0] rd;
    logic            is_load;
  } sb_entry_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  // MEM wins over WB; a load in MEM has no result yet, so it falls through to WB.
  function automatic fwd_sel_e fwd_pick(sb_entry_t mem, sb_entry_t wb, logic [RD_W-1:0] rs);
    fwd_pick = FWD_RF;
    if (rs != '0) begin
      if (mem.valid && !mem.is_load && (mem.rd == rs)) fwd_pick = FWD_EXMEM;
      else if (wb.valid && (wb.rd == rs))              fwd_pick = FWD_MEMWB;
    end
  endfunction

endpackage

// File: rtl/hz_scoreboard.sv
// In-flight destination tracker for EX/MEM/WB plus the EX operand forwarding compare.
module hz_scoreboard
  import pipe_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift,
  input  logic             drain,
  input  sb_entry_t        id_entry,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  output sb_entry_t        ex_entry,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  sb_entry_t ex_q, mem_q, wb_q;

  // Shift with the pipe; drain only moves the back end and leaves a bubble in EX.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else if (shift) begin
      ex_q  <= id_entry;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end else if (drain) begin
      ex_q  <= '0;
      mem_q <= ex_q;
      wb_q  <= mem_q;
    end
  end

  assign ex_entry = ex_q;

  always_comb begin
    fwd_a = fwd_pick(mem_q, wb_q, RD_W'(ex_rs1));
    fwd_b = fwd_pick(mem_q, wb_q, RD_W'(ex_rs2));
  end

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Pipeline hazard/flush controller: RUN/SQUASH/WAIT FSM, load-use bubble and scoreboard hookup.
module hazard_flush_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned REG_W        = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_is_load,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             flag,
  output logic             pc_replace,
  output logic             if_id_hold,
  output logic             pc_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       state_dbg
);

  localparam logic [1:0] S_RUN    = RUN;
  localparam logic [1:0] S_SQUASH = SQUASH;
  localparam logic [1:0] S_WAIT   = WAIT;
  localparam logic [1:0] CNT_LOAD = 2'(FLUSH_CYCLES - 1);

  logic [1:0] state, state_d;
  logic [1:0] saved, saved_d;
  logic [1:0] cnt, cnt_d;
  logic       pend, pend_d;
  logic       load_use;
  sb_entry_t  id_entry, ex_entry;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_RUN;
      saved <= S_RUN;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      state <= state_d;
      saved <= saved_d;
      cnt   <= cnt_d;
      pend  <= pend_d;
    end
  end

  // Load-use only matters when nothing of higher priority is happening this cycle.
  always_comb begin
    load_use = ex_entry.valid && ex_entry.is_load && (ex_entry.rd != '0) &&
               ((id_uses_rs1 && (RD_W'(id_rs1) == ex_entry.rd)) ||
                (id_uses_rs2 && (RD_W'(id_rs2) == ex_entry.rd))) &&
               !ex_redirect && !mem_busy;
  end

  // Next state and decoded controls.
  always_comb begin
    state_d    = state;
    saved_d    = saved;
    cnt_d      = cnt;
    pend_d     = pend;
    flag       = 1'b0;
    pc_replace = 1'b1;
    if_id_hold = 1'b0;
    pc_hold    = 1'b0;

    case (state)
      S_WAIT: begin
        if (ex_redirect) pend_d = 1'b1;
        if (!mem_busy) begin
          pend_d = 1'b0;
          if (pend || ex_redirect) begin
            state_d = S_SQUASH;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = saved;
          end
        end
      end
      S_RUN, S_SQUASH: begin
        if ((state == S_SQUASH) && (cnt != '0)) cnt_d = cnt - 2'd1;
        if (ex_redirect && mem_busy) begin
          state_d = S_WAIT;
          pend_d  = 1'b1;
        end else if (ex_redirect) begin
          state_d = S_SQUASH;
          cnt_d   = CNT_LOAD;
        end else if (mem_busy) begin
          // This squash cycle already counted; resume with whatever is left.
          state_d = S_WAIT;
          saved_d = ((state == S_SQUASH) && (cnt != '0)) ? S_SQUASH : S_RUN;
        end else if ((state == S_SQUASH) && (cnt == '0)) begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_RUN;
    endcase

    if (!reset) begin
      case (state)
        S_SQUASH: begin
          flag       = 1'b1;
          pc_replace = 1'b1;
        end
        S_WAIT: begin
          pc_replace = 1'b0;
          if_id_hold = 1'b1;
          pc_hold    = 1'b1;
        end
        default: begin
          flag       = 1'b1;
          pc_replace = load_use;
          if_id_hold = load_use;
          pc_hold    = load_use;
        end
      endcase
    end
  end

  always_comb begin
    id_entry.valid   = !pc_replace && id_reg_write && (id_rd != '0);
    id_entry.rd      = RD_W'(id_rd);
    id_entry.is_load = id_is_load;
  end

  hz_scoreboard #(.REG_W(REG_W)) u_sb (
    .clk      (clk),
    .reset    (reset),
    .shift    (flag),
    .drain    (!flag && (state != S_WAIT) && !reset),
    .id_entry (id_entry),
    .ex_rs1   (ex_rs1),
    .ex_rs2   (ex_rs2),
    .ex_entry (ex_entry),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b)
  );

  assign state_dbg = state;

endmodule
